eb_fifo: RTL
============

Name: eb_fifo

Overview:
- Parametrised N-slot elastic buffer. Next generation of the team's 2-slot elastic controller, generalised to arbitrary depth and width.
- Adds occupancy reporting, an almost-full flag and a synchronous flush.
- Sits between any two req/ack elastic channels: t_* is the upstream target side, i_* is the downstream initiator side.
- Full throughput (one transfer per cycle) at DEPTH >= 2. No combinational path from i_* to t_* or from t_* to i_*.

Parameters:
- W, 32: data width in bits, >= 1.
- DEPTH, 4: number of storage slots, >= 2. Need not be a power of two.
- AF, DEPTH-1: almost-full threshold, 1..DEPTH.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of all stored entries.
- t_dat  input  W  upstream data.
- t_req  input  1  upstream request (data valid).
- t_ack  output  1  upstream acknowledge (space available).
- i_dat  output  W  downstream data.
- i_req  output  1  downstream request (data valid).
- i_ack  input  1  downstream acknowledge.
- cnt  output  CW  occupancy, CW = clog2(DEPTH+1).
- afull  output  1  cnt >= AF.

Behaviour:
- Handshake rules:
  - Push occurs in a cycle when t_req & t_ack. Pop occurs when i_req & i_ack.
  - t_req/t_dat may change freely when t_ack=0. No stability requirement on either side is imposed by this block.
- Registered state: wr_ptr, rd_ptr (0..DEPTH-1, wrap DEPTH-1 -> 0 explicitly, not by truncation), cnt (0..DEPTH). Storage is an array of DEPTH x W flops with no reset.
- Output derivation:
  - t_ack = (cnt != DEPTH), derived from registered state only. It does not depend on i_ack, so a full buffer refuses even while being drained.
  - i_req = (cnt != 0).
  - i_dat = mem[rd_ptr].
  - afull = (cnt >= AF).
  - All outputs are decodes of flops.
- Latency: a word pushed in cycle k is presented on i_dat/i_req from cycle k+1. There is no bypass path. Ordering is strict FIFO.
- Per-cycle update, flush low:
  - Push only: mem[wr_ptr] <= t_dat, wr_ptr++, cnt++.
  - Pop only: rd_ptr++, cnt--.
  - Push and pop together: both pointers advance, cnt unchanged. Legal at any 0 < cnt < DEPTH. Cannot occur at cnt=0 (i_req=0) or cnt=DEPTH (t_ack=0).
  - Neither: hold.
- Flush high (highest priority): next cycle wr_ptr=rd_ptr=0 and cnt=0. Any push or pop handshake in the flush cycle is discarded. Upstream sees t_ack as computed in that cycle, and the word is lost by definition.
- Reset (asserted at any time, including mid-transfer): pointers and cnt cleared asynchronously. During and after reset: t_ack=1, i_req=0, cnt=0, afull=0 (afull=1 only if AF would be 0, which is illegal). i_dat is undefined until the first push. Deassertion is synchronised externally.
- Error handling: no overflow/underflow is possible through the protocol. Simulation assertions check cnt <= DEPTH and pointer range.
- Equivalence: DEPTH=2 must be cycle-equivalent on t_ack/i_req/i_dat to the existing 2-slot elastic controller, except that t_ack is low only when 2 words are held.

Decomposition:
- Shared package eb_pkg:
  - clog2 constant function.
  - Localparams AW = clog2(DEPTH), CW = clog2(DEPTH+1), derived in-module from the function.
- Sub-module eb_ptr:
  - Parameters DEPTH and AW.
  - Ports clk, reset_n, clr, inc, ptr.
  - Wrap-around counter instantiated twice (write and read pointers).
  - clr has priority over inc.

Test Plan:
- Fill: W=8, DEPTH=4, i_ack=0, push 0x11,0x22,0x33,0x44 on consecutive cycles -> cnt 1,2,3,4; afull rises at cnt=3; t_ack=0 after the 4th push; a 5th t_req with 0x55 is not accepted.
- Drain: from full, i_ack=1 for 4 cycles -> i_dat 0x11,0x22,0x33,0x44 in order; i_req=0 after the last pop; t_ack=1 from the first pop cycle +1.
- Streaming: t_req=i_ack=1 continuously with 100 incrementing words, DEPTH=3 -> after 1 fill cycle, one word out per cycle, cnt stays 1, no drops, pointer wrap 2->0 exercised.
- Full-with-ack: cnt=4, t_req=1, i_ack=1 -> pop only; cnt=3 next cycle; push accepted in the following cycle.
- Flush: cnt=2, flush=1 with simultaneous t_req=1 (0xAA) and i_ack=1 -> next cycle cnt=0, i_req=0; the next push 0xBB appears first on i_dat.
- Reset mid-operation: cnt=3, drop reset_n between clock edges -> i_req=0, cnt=0, t_ack=1 immediately without a clock edge; after release a push of 0x5A is read back correctly.

Source files
------------

// File: rtl/eb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eb_pkg
//  Purpose  : Shared helpers for the elastic buffer (width computation).
//  Revision : 1.0  initial release
// ============================================================================
package eb_pkg;

    // Ceiling log2; returns 0 for n <= 1. Used to size pointers and counters.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage : eb_pkg
`default_nettype wire

// File: rtl/eb_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : eb_ptr
//  Purpose  : Wrap-around slot pointer 0..DEPTH-1 with clear (priority) and
//             increment. Wrap is explicit so non-power-of-two depths work.
//  Revision : 1.0  initial release
// ============================================================================
module eb_ptr #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    logic [AW-1:0] r_ptr;

    // Pointer register: clear beats increment, last slot wraps to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == c_LAST) ? '0 : r_ptr + AW'(1);
        end
    end

    assign ptr = r_ptr;

endmodule : eb_ptr
`default_nettype wire

// File: rtl/eb_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : eb_fifo
//  Purpose  : N-slot elastic buffer between two req/ack channels with
//             occupancy count, almost-full flag and synchronous flush.
//             All outputs decode registered state only, so there is no
//             combinational path between the upstream and downstream sides.
//  Revision : 1.0  initial release
// ============================================================================
module eb_fifo
    import eb_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int AF    = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic [W-1:0]                 t_dat,
    input  logic                         t_req,
    output logic                         t_ack,
    output logic [W-1:0]                 i_dat,
    output logic                         i_req,
    input  logic                         i_ack,
    output logic [clog2(DEPTH+1)-1:0]    cnt,
    output logic                         afull
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] c_AF   = CW'(AF);
    localparam logic [AW:0]   c_SLOTS = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_ptr;
    logic          w_t_ack;
    logic          w_i_req;
    logic          w_push;
    logic          w_pop;

    assign w_t_ack = (r_cnt != c_FULL);
    assign w_i_req = (r_cnt != '0);
    assign w_push  = t_req & w_t_ack;
    assign w_pop   = w_i_req & i_ack;

    eb_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (w_push),
        .ptr     (w_wr_ptr)
    );

    eb_ptr #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (flush),
        .inc     (w_pop),
        .ptr     (w_rd_ptr)
    );

    // Storage write: data flops carry no reset; a flushed push is dropped.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[w_wr_ptr] <= t_dat;
        end
    end

    // Occupancy: flush clears, push/pop adjust, simultaneous push+pop holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign t_ack = w_t_ack;
    assign i_req = w_i_req;
    assign i_dat = r_mem[w_rd_ptr];
    assign cnt   = r_cnt;
    assign afull = (r_cnt >= c_AF);

`ifndef SYNTHESIS
    // State sanity: occupancy and pointers must stay inside their ranges.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (r_cnt <= c_FULL);
            assert ({1'b0, w_wr_ptr} < c_SLOTS);
            assert ({1'b0, w_rd_ptr} < c_SLOTS);
        end
    end
`endif

endmodule : eb_fifo
`default_nettype wire
